// File: rtl/matrix_result_reader.sv
// ----------------------------------------------------------------------------
// matrix_result_reader
//
// Purpose:
//   Downstream reader for matrix_mult_vector product frames. A rising edge on
//   i_ready captures the flattened MATRIX_HEIGHT x MATRIX_WIDTH product array.
//   Each row is then reduced to an unsigned sum, one element per clock, and
//   the row sums are streamed out over a valid/accept handshake.
//
// Ports:
//   clk       in   1            single clock, all logic on posedge
//   i_rst_n   in   1            synchronous active-low reset
//   i_ready   in   1            product-valid level from the multiplier
//   i_result  in   MATRIX_SIZE  flattened products, element e at [e*DATA_WIDTH +: DATA_WIDTH]
//   o_busy    out  1            a frame is held and not yet fully delivered
//   o_valid   out  1            o_data/o_row carry a row sum
//   i_accept  in   1            consumer takes o_data on an edge where o_valid=1
//   o_data    out  SUM_WIDTH    row sum
//   o_row     out  ROW_WIDTH    row index of o_data
//   o_done    out  1            one-cycle pulse after the final row is accepted
//   o_drop    out  1            one-cycle pulse when an i_ready rise is ignored while busy
// ----------------------------------------------------------------------------
module matrix_result_reader #(
    parameter int MATRIX_WIDTH  = 5,
    parameter int MATRIX_HEIGHT = 5,
    parameter int DATA_WIDTH    = 8,
    parameter int SUM_WIDTH     = DATA_WIDTH + $clog2(MATRIX_WIDTH),
    parameter int ROW_WIDTH     = ($clog2(MATRIX_HEIGHT) > 0) ? $clog2(MATRIX_HEIGHT) : 1,
    parameter int MATRIX_SIZE   = MATRIX_WIDTH * MATRIX_HEIGHT * DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_ready,
    input  logic [MATRIX_SIZE-1:0] i_result,
    output logic                   o_busy,
    output logic                   o_valid,
    input  logic                   i_accept,
    output logic [SUM_WIDTH-1:0]   o_data,
    output logic [ROW_WIDTH-1:0]   o_row,
    output logic                   o_done,
    output logic                   o_drop
);

    localparam int COL_WIDTH = ($clog2(MATRIX_WIDTH) > 0) ? $clog2(MATRIX_WIDTH) : 1;
    localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(MATRIX_WIDTH - 1);
    localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(MATRIX_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    // The packed layout puts element [r][c] at bit offset (r*W + c)*DATA_WIDTH,
    // which is exactly the flattened ordering of i_result.
    typedef logic [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] frame_t;

    state_t                 state, state_next;
    logic                   ready_q;
    frame_t                 frame, frame_next;
    logic [SUM_WIDTH-1:0]   acc, acc_next;
    logic [ROW_WIDTH-1:0]   row, row_next;
    logic [COL_WIDTH-1:0]   col, col_next;
    logic                   busy_next;
    logic                   valid_next;
    logic [SUM_WIDTH-1:0]   data_next;
    logic [ROW_WIDTH-1:0]   row_out_next;
    logic                   done_next;
    logic                   drop_next;
    logic                   rise;
    logic [SUM_WIDTH-1:0]   elem_sum;

    // Only a low-to-high transition starts a frame; a held-high level never re-triggers.
    assign rise     = i_ready & ~ready_q;
    assign elem_sum = acc + SUM_WIDTH'(frame[row][col]);

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            frame   <= '0;
            acc     <= '0;
            row     <= '0;
            col     <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_row   <= '0;
            o_done  <= 1'b0;
            o_drop  <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= i_ready;
            frame   <= frame_next;
            acc     <= acc_next;
            row     <= row_next;
            col     <= col_next;
            o_busy  <= busy_next;
            o_valid <= valid_next;
            o_data  <= data_next;
            o_row   <= row_out_next;
            o_done  <= done_next;
            o_drop  <= drop_next;
        end
    end

    always_comb begin
        state_next   = state;
        frame_next   = frame;
        acc_next     = acc;
        row_next     = row;
        col_next     = col;
        busy_next    = o_busy;
        valid_next   = o_valid;
        data_next    = o_data;
        row_out_next = o_row;
        done_next    = 1'b0;
        drop_next    = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    frame_next = i_result;
                    row_next   = '0;
                    col_next   = '0;
                    acc_next   = '0;
                    busy_next  = 1'b1;
                    state_next = ACCUM;
                end
            end

            ACCUM: begin
                // A new frame arriving now has nowhere to go; report and discard it.
                drop_next = rise;
                acc_next  = elem_sum;
                if (col == LAST_COL) begin
                    data_next    = elem_sum;
                    row_out_next = row;
                    valid_next   = 1'b1;
                    state_next   = OUT;
                end else begin
                    col_next = col + 1'b1;
                end
            end

            OUT: begin
                // Still busy here, even on the final accept edge.
                drop_next = rise;
                if (i_accept) begin
                    valid_next = 1'b0;
                    if (row == LAST_ROW) begin
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        row_next   = row + 1'b1;
                        col_next   = '0;
                        acc_next   = '0;
                        state_next = ACCUM;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_result_reader.sv
// ----------------------------------------------------------------------------
// tb_matrix_result_reader
//
// Purpose:
//   Scoreboard bench for matrix_result_reader. The monitor keeps a frame-level
//   model: on each accepted i_ready rise it computes the row sums from the
//   captured products and queues them; it predicts handshake timing, o_busy,
//   o_done and o_drop, and compares every cycle on the falling edge.
//   Inputs are driven 2 time units after each rising edge.
// ----------------------------------------------------------------------------
module tb_matrix_result_reader;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int DW = 8;
    localparam int SW = DW + $clog2(W);
    localparam int RW = ($clog2(H) > 0) ? $clog2(H) : 1;
    localparam int MS = W * H * DW;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_ready = 1'b0;
    logic [MS-1:0] i_result = '0;
    logic          o_busy;
    logic          o_valid;
    logic          i_accept = 1'b0;
    logic [SW-1:0] o_data;
    logic [RW-1:0] o_row;
    logic          o_done;
    logic          o_drop;

    matrix_result_reader #(
        .MATRIX_WIDTH (W),
        .MATRIX_HEIGHT(H),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_ready (i_ready),
        .i_result(i_result),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .i_accept(i_accept),
        .o_data  (o_data),
        .o_row   (o_row),
        .o_done  (o_done),
        .o_drop  (o_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int sum;
        bit last;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int fails  = 0;

    // Model state, updated by the monitor only.
    bit m_busy    = 1'b0;
    bit exp_valid = 1'b0;
    bit exp_done  = 1'b0;
    bit exp_drop  = 1'b0;
    bit prev_rdy  = 1'b0;
    int eta       = -1;

    // Accept driver controls.
    bit accept_hold   = 1'b0;
    bit random_accept = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [MS-1:0] randomFrame();
        logic [MS-1:0] v;
        v = '0;
        for (int e = 0; e < W * H; e++) v[e*DW +: DW] = DW'($urandom_range(0, 255));
        return v;
    endfunction

    function automatic logic [MS-1:0] constFrame(input int value);
        logic [MS-1:0] v;
        v = '0;
        for (int e = 0; e < W * H; e++) v[e*DW +: DW] = DW'(value);
        return v;
    endfunction

    function automatic logic [MS-1:0] indexFrame();
        logic [MS-1:0] v;
        v = '0;
        for (int e = 0; e < W * H; e++) v[e*DW +: DW] = DW'(e);
        return v;
    endfunction

    // One-cycle i_ready pulse carrying a frame; afterwards i_result holds junk
    // so that late sampling would corrupt the sums.
    task automatic applyStimulus(input logic [MS-1:0] frame);
        @(posedge clk) #2;
        i_result = frame;
        i_ready  = 1'b1;
        @(posedge clk) #2;
        i_ready  = 1'b0;
        i_result = randomFrame();
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((m_busy || sb.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("frame_complete_in_time", 64'(n < 3000), 64'd1);
        repeat (3) @(posedge clk);
    endtask

    task automatic waitRowValid(input int r);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(o_valid === 1'b1 && o_row == RW'(r)) && n < 500);
        checkOutput("row_valid_seen", 64'(n < 500), 64'd1);
    endtask

    // Accept driver.
    initial begin
        forever begin
            @(posedge clk) #2;
            if (accept_hold)        i_accept = 1'b0;
            else if (random_accept) i_accept = 1'($urandom_range(0, 1));
            else                    i_accept = 1'b1;
        end
    end

    // Monitor: compare against predictions, then advance the model using the
    // inputs that the coming rising edge will sample.
    initial begin
        exp_t e;
        bit   rise;
        bit   was_busy;
        int   s;
        @(posedge clk);
        forever begin
            @(negedge clk);
            checkOutput("o_valid", 64'(o_valid), 64'(exp_valid));
            checkOutput("o_busy",  64'(o_busy),  64'(m_busy));
            checkOutput("o_done",  64'(o_done),  64'(exp_done));
            checkOutput("o_drop",  64'(o_drop),  64'(exp_drop));
            if (exp_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("scoreboard_nonempty", 64'd0, 64'd1);
                end else begin
                    checkOutput("o_data", 64'(o_data), 64'(sb[0].sum));
                    checkOutput("o_row",  64'(o_row),  64'(sb[0].row));
                end
            end

            if (!i_rst_n) begin
                sb.delete();
                m_busy    = 1'b0;
                exp_valid = 1'b0;
                exp_done  = 1'b0;
                exp_drop  = 1'b0;
                prev_rdy  = 1'b0;
                eta       = -1;
            end else begin
                rise     = i_ready && !prev_rdy;
                prev_rdy = i_ready;
                was_busy = m_busy;
                exp_done = 1'b0;
                exp_drop = 1'b0;
                if (eta > 0) begin
                    eta--;
                    if (eta == 0) exp_valid = 1'b1;
                end else if (exp_valid && i_accept) begin
                    exp_valid = 1'b0;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        if (e.last) begin
                            exp_done = 1'b1;
                            m_busy   = 1'b0;
                            eta      = -1;
                        end else begin
                            eta = W;
                        end
                    end
                end
                if (rise) begin
                    if (was_busy) begin
                        exp_drop = 1'b1;
                    end else begin
                        for (int r = 0; r < H; r++) begin
                            s = 0;
                            for (int c = 0; c < W; c++) s += int'(i_result[(r*W + c)*DW +: DW]);
                            sb.push_back('{row: r, sum: s, last: (r == H - 1)});
                        end
                        m_busy = 1'b1;
                        eta    = W;
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        repeat (3) @(posedge clk);
        #2 i_rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] all-ones frame");
        applyStimulus(constFrame(1));
        waitIdle();

        $display("[TB] all-0xFF frame");
        applyStimulus(constFrame(255));
        waitIdle();

        $display("[TB] element index frame");
        applyStimulus(indexFrame());
        waitIdle();

        $display("[TB] accept held low on row 2");
        applyStimulus(randomFrame());
        waitRowValid(1);
        accept_hold = 1'b1;
        waitRowValid(2);
        repeat (7) @(posedge clk);
        accept_hold = 1'b0;
        waitIdle();

        $display("[TB] i_ready toggle during row 1, held high across frame end");
        @(posedge clk) #2;
        i_result = randomFrame();
        i_ready  = 1'b1;
        @(posedge clk) #2;
        i_result = randomFrame();
        waitRowValid(1);
        @(posedge clk) #2;
        i_ready = 1'b0;
        @(posedge clk) #2;
        i_ready = 1'b1;
        waitIdle();
        repeat (3) @(posedge clk);
        #2 i_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] reset during row 3 accumulation");
        applyStimulus(randomFrame());
        waitRowValid(2);
        @(posedge clk);
        @(posedge clk) #2;
        i_rst_n = 1'b0;
        @(posedge clk) #2;
        i_rst_n = 1'b1;
        waitIdle();
        applyStimulus(randomFrame());
        waitIdle();

        $display("[TB] randomized frames and accepts");
        random_accept = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk) #2;
            i_ready  = ($urandom_range(0, 5) == 0);
            i_result = randomFrame();
        end
        @(posedge clk) #2;
        i_ready = 1'b0;
        waitIdle();
        random_accept = 1'b0;

        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
